// File: rtl/mold_ab_arbiter.sv
// rtl/mold_ab_arbiter.sv - merges redundant A/B MoldUDP64 feeds into one in-order, de-duplicated ITCH byte stream
module mold_ab_arbiter #(
  parameter logic [63:0] INIT_SEQ = 64'd1
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        aHdrValidIn,
  input  logic [63:0] aSeqNumIn,
  input  logic [15:0] aMsgCntIn,
  input  logic [7:0]  aDataIn,
  input  logic        aDataValidIn,
  input  logic        aLastIn,
  input  logic        aDataErrIn,
  input  logic        bHdrValidIn,
  input  logic [63:0] bSeqNumIn,
  input  logic [15:0] bMsgCntIn,
  input  logic [7:0]  bDataIn,
  input  logic        bDataValidIn,
  input  logic        bLastIn,
  input  logic        bDataErrIn,
  output logic [7:0]  itchDataOut,
  output logic        itchDataValidOut,
  output logic        itchLastOut,
  output logic        itchErrOut,
  output logic [63:0] expSeqOut,
  output logic        gapOut,
  output logic [63:0] gapStartOut,
  output logic [15:0] gapLenOut,
  output logic        eosOut,
  output logic [31:0] dupCntOut,
  output logic [31:0] busyDropCntOut,
  output logic [31:0] errCntOut
);
  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

  logic [1:0]  w_hdr, w_dv, w_last, w_err;
  logic [63:0] w_seq [2];
  logic [15:0] w_cnt [2];
  logic [7:0]  w_data [2];

  assign w_hdr     = {bHdrValidIn, aHdrValidIn};
  assign w_dv      = {bDataValidIn, aDataValidIn};
  assign w_last    = {bLastIn, aLastIn};
  assign w_err     = {bDataErrIn, aDataErrIn};
  assign w_seq[0]  = aSeqNumIn;
  assign w_seq[1]  = bSeqNumIn;
  assign w_cnt[0]  = aMsgCntIn;
  assign w_cnt[1]  = bMsgCntIn;
  assign w_data[0] = aDataIn;
  assign w_data[1] = bDataIn;

  state_t      r_state [2];
  owner_t      r_owner;
  logic [63:0] r_exp;
  logic [63:0] r_pkt [2];
  // Rollback is only legal while exp still reflects this feed's own header.
  logic [1:0]  r_rbok;
  logic [7:0]  r_odata;
  logic        r_ov, r_olast, r_oerr;
  logic        r_gap;
  logic [63:0] r_gap_start;
  logic [15:0] r_gap_len;
  logic        r_eos;
  logic [31:0] r_dup, r_busy, r_errc;

  state_t      w_state_n [2];
  owner_t      w_owner_n;
  logic [63:0] w_exp_n;
  logic [63:0] w_pkt_n [2];
  logic [1:0]  w_rbok_n;
  logic [7:0]  w_odata;
  logic        w_ov, w_olast, w_oerr;
  logic        w_gap;
  logic [63:0] w_gap_start;
  logic [15:0] w_gap_len;
  logic        w_eos;
  logic [1:0]  w_dup_inc, w_busy_inc, w_err_inc;
  logic [63:0] w_diff;

  always_comb begin
    for (int f = 0; f < 2; f++) begin
      w_state_n[f] = r_state[f];
      w_pkt_n[f]   = r_pkt[f];
    end
    w_owner_n   = r_owner;
    w_exp_n     = r_exp;
    w_rbok_n    = r_rbok;
    w_odata     = 8'd0;
    w_ov        = 1'b0;
    w_olast     = 1'b0;
    w_oerr      = 1'b0;
    w_gap       = 1'b0;
    w_gap_start = r_gap_start;
    w_gap_len   = r_gap_len;
    w_eos       = 1'b0;
    w_dup_inc   = 2'd0;
    w_busy_inc  = 2'd0;
    w_err_inc   = 2'd0;
    w_diff      = 64'd0;

    // Running packets first: forward, terminate, or abort on a new header.
    for (int f = 0; f < 2; f++) begin
      if (r_state[f] == ST_FWD) begin
        if (w_hdr[f]) begin
          w_ov      = 1'b1;
          w_olast   = 1'b1;
          w_oerr    = 1'b1;
          w_err_inc = w_err_inc + 2'd1;
          if (r_rbok[f]) w_exp_n = r_pkt[f];
          w_state_n[f] = ST_IDLE;
          w_owner_n    = OWN_NONE;
          w_rbok_n[f]  = 1'b0;
        end else if (w_dv[f]) begin
          w_ov    = 1'b1;
          w_odata = w_data[f];
          w_olast = w_last[f] | w_err[f];
          w_oerr  = w_err[f];
          if (w_err[f]) begin
            w_err_inc = w_err_inc + 2'd1;
            if (r_rbok[f]) w_exp_n = r_pkt[f];
          end
          if (w_last[f] | w_err[f]) begin
            w_state_n[f] = ST_IDLE;
            w_owner_n    = OWN_NONE;
            w_rbok_n[f]  = 1'b0;
          end
        end
      end else if (r_state[f] == ST_DROP && !w_hdr[f] && w_dv[f] && (w_last[f] | w_err[f])) begin
        w_state_n[f] = ST_IDLE;
      end
    end

    // Header classification: A then B, each against the updated exp and owner.
    for (int f = 0; f < 2; f++) begin
      if (w_hdr[f]) begin
        w_diff = w_seq[f] - w_exp_n;
        if (w_cnt[f] == 16'd0 || w_cnt[f] == 16'hFFFF) begin
          if (w_seq[f] > w_exp_n) begin
            w_gap       = 1'b1;
            w_gap_start = w_exp_n;
            w_gap_len   = (w_diff > 64'hFFFF) ? 16'hFFFF : w_diff[15:0];
            w_exp_n     = w_seq[f];
            w_rbok_n    = 2'b00;
          end
          if (w_cnt[f] == 16'hFFFF) w_eos = 1'b1;
          w_state_n[f] = ST_DROP;
        end else if (w_seq[f] < w_exp_n) begin
          w_dup_inc    = w_dup_inc + 2'd1;
          w_state_n[f] = ST_DROP;
        end else if (w_owner_n != OWN_NONE) begin
          w_busy_inc   = w_busy_inc + 2'd1;
          w_state_n[f] = ST_DROP;
        end else begin
          if (w_seq[f] > w_exp_n) begin
            w_gap       = 1'b1;
            w_gap_start = w_exp_n;
            w_gap_len   = (w_diff > 64'hFFFF) ? 16'hFFFF : w_diff[15:0];
          end
          w_state_n[f] = ST_FWD;
          w_owner_n    = (f == 0) ? OWN_A : OWN_B;
          w_pkt_n[f]   = w_seq[f];
          w_exp_n      = w_seq[f] + {48'd0, w_cnt[f]};
          w_rbok_n     = 2'b00;
          w_rbok_n[f]  = 1'b1;
        end
        if (w_dv[f]) begin
          if (w_state_n[f] == ST_FWD) begin
            if (!w_ov) begin
              w_ov    = 1'b1;
              w_odata = w_data[f];
              w_olast = w_last[f] | w_err[f];
              w_oerr  = w_err[f];
            end
            if (w_err[f]) begin
              w_err_inc = w_err_inc + 2'd1;
              w_exp_n   = w_seq[f];
            end
            if (w_last[f] | w_err[f]) begin
              w_state_n[f] = ST_IDLE;
              w_owner_n    = OWN_NONE;
              w_rbok_n[f]  = 1'b0;
            end
          end else if (w_last[f] | w_err[f]) begin
            w_state_n[f] = ST_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_state[0]  <= ST_IDLE;
      r_state[1]  <= ST_IDLE;
      r_pkt[0]    <= 64'd0;
      r_pkt[1]    <= 64'd0;
      r_owner     <= OWN_NONE;
      r_exp       <= INIT_SEQ;
      r_rbok      <= 2'b00;
      r_odata     <= 8'd0;
      r_ov        <= 1'b0;
      r_olast     <= 1'b0;
      r_oerr      <= 1'b0;
      r_gap       <= 1'b0;
      r_gap_start <= 64'd0;
      r_gap_len   <= 16'd0;
      r_eos       <= 1'b0;
      r_dup       <= 32'd0;
      r_busy      <= 32'd0;
      r_errc      <= 32'd0;
    end else begin
      r_state[0]  <= w_state_n[0];
      r_state[1]  <= w_state_n[1];
      r_pkt[0]    <= w_pkt_n[0];
      r_pkt[1]    <= w_pkt_n[1];
      r_owner     <= w_owner_n;
      r_exp       <= w_exp_n;
      r_rbok      <= w_rbok_n;
      r_odata     <= w_odata;
      r_ov        <= w_ov;
      r_olast     <= w_olast;
      r_oerr      <= w_oerr;
      r_gap       <= w_gap;
      r_gap_start <= w_gap_start;
      r_gap_len   <= w_gap_len;
      r_eos       <= r_eos | w_eos;
      r_dup       <= r_dup + {30'd0, w_dup_inc};
      r_busy      <= r_busy + {30'd0, w_busy_inc};
      r_errc      <= r_errc + {30'd0, w_err_inc};
    end
  end

  assign itchDataOut      = r_odata;
  assign itchDataValidOut = r_ov;
  assign itchLastOut      = r_olast;
  assign itchErrOut       = r_oerr;
  assign expSeqOut        = r_exp;
  assign gapOut           = r_gap;
  assign gapStartOut      = r_gap_start;
  assign gapLenOut        = r_gap_len;
  assign eosOut           = r_eos;
  assign dupCntOut        = r_dup;
  assign busyDropCntOut   = r_busy;
  assign errCntOut        = r_errc;
endmodule

// File: tb/tb_mold_ab_arbiter.sv
// tb/tb_mold_ab_arbiter.sv - directed self-checking bench for mold_ab_arbiter
module tb_mold_ab_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aHdr, aDv, aLast, aErr, bHdr, bDv, bLast, bErr;
  logic [63:0] aSeq, bSeq;
  logic [15:0] aCnt, bCnt;
  logic [7:0]  aData, bData;
  logic [7:0]  itchData;
  logic        itchValid, itchLast, itchErrO, gap, eos;
  logic [63:0] expSeq, gapStart;
  logic [15:0] gapLen;
  logic [31:0] dupCnt, busyCnt, errCnt;

  int checks = 0;
  int errors = 0;
  logic [9:0] q[$];

  mold_ab_arbiter #(.INIT_SEQ(64'd1)) dut (
    .clkIn(clk), .rstIn(rst),
    .aHdrValidIn(aHdr), .aSeqNumIn(aSeq), .aMsgCntIn(aCnt), .aDataIn(aData),
    .aDataValidIn(aDv), .aLastIn(aLast), .aDataErrIn(aErr),
    .bHdrValidIn(bHdr), .bSeqNumIn(bSeq), .bMsgCntIn(bCnt), .bDataIn(bData),
    .bDataValidIn(bDv), .bLastIn(bLast), .bDataErrIn(bErr),
    .itchDataOut(itchData), .itchDataValidOut(itchValid), .itchLastOut(itchLast),
    .itchErrOut(itchErrO), .expSeqOut(expSeq), .gapOut(gap), .gapStartOut(gapStart),
    .gapLenOut(gapLen), .eosOut(eos), .dupCntOut(dupCnt), .busyDropCntOut(busyCnt),
    .errCntOut(errCnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (itchValid) q.push_back({itchErrO, itchLast, itchData});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic clr();
    aHdr = 0; aDv = 0; aLast = 0; aErr = 0; aData = 8'd0;
    bHdr = 0; bDv = 0; bLast = 0; bErr = 0; bData = 8'd0;
  endtask

  // Expected packet: bytes base+k, Last on the final byte, Err there if term_err.
  task automatic chk_pkt(input string tag, input int n, input int base, input bit term_err);
    int m;
    logic [9:0] e;
    m = 0;
    chk({tag, " count"}, 64'(q.size()), 64'(n));
    if (q.size() == n) begin
      for (int k = 0; k < n; k++) begin
        e = {(k == n - 1) && term_err, k == n - 1, 8'(base + k)};
        if (q[k] !== e) m++;
      end
      chk({tag, " bytes"}, 64'(m), 64'd0);
    end
    q.delete();
  endtask

  initial begin
    clr();
    aSeq = 0; aCnt = 0; bSeq = 0; bCnt = 0;
    tick(); tick();
    chk("rst exp", expSeq, 64'd1);
    chk("rst valid", {63'd0, itchValid}, 64'd0);
    chk("rst cnts", {dupCnt, busyCnt | errCnt}, 64'd0);
    chk("rst gap/eos", {gapStart[31:0], gapLen, 14'd0, gap, eos}, 64'd0);
    rst = 0;

    // In-order A only
    aHdr = 1; aSeq = 64'd1; aCnt = 16'd1;
    tick(); clr();
    chk("t1 exp", expSeq, 64'd2);
    for (int i = 0; i < 125; i++) begin
      aDv = 1; aData = 8'(i); aLast = (i == 124);
      tick();
      if (i == 0) chk("t1 latency", {55'd0, itchValid, itchData}, {55'd0, 1'b1, 8'd0});
    end
    clr(); tick(); tick();
    chk_pkt("t1", 125, 0, 0);

    rst = 1; tick(); rst = 0; q.delete();
    chk("reset2 exp", expSeq, 64'd1);

    // Simultaneous duplicate headers
    aHdr = 1; aSeq = 64'd1; aCnt = 16'd1;
    bHdr = 1; bSeq = 64'd1; bCnt = 16'd1;
    tick(); clr();
    chk("t2 dup", 64'(dupCnt), 64'd1);
    chk("t2 exp", expSeq, 64'd2);
    for (int i = 0; i < 4; i++) begin
      aDv = 1; aData = 8'(8'h10 + i); aLast = (i == 3);
      bDv = 1; bData = 8'(8'h80 + i); bLast = (i == 3);
      tick();
    end
    clr(); tick(); tick();
    chk_pkt("t2", 4, 8'h10, 0);
    chk("t2 busy", 64'(busyCnt), 64'd0);

    // Gap on B
    bHdr = 1; bSeq = 64'd5; bCnt = 16'd2;
    tick(); clr();
    chk("t3 gap", {63'd0, gap}, 64'd1);
    chk("t3 gapStart", gapStart, 64'd2);
    chk("t3 gapLen", 64'(gapLen), 64'd3);
    chk("t3 exp", expSeq, 64'd7);
    for (int i = 0; i < 3; i++) begin
      bDv = 1; bData = 8'(8'h20 + i); bLast = (i == 2);
      tick();
      if (i == 0) chk("t3 gap pulse", {63'd0, gap}, 64'd0);
    end
    clr(); tick(); tick();
    chk_pkt("t3", 3, 8'h20, 0);

    // Busy drop of B while A forwards
    aHdr = 1; aSeq = 64'd7; aCnt = 16'd1;
    tick(); clr();
    chk("t4 exp", expSeq, 64'd8);
    for (int i = 0; i < 6; i++) begin
      aDv = 1; aData = 8'(8'h30 + i); aLast = (i == 5);
      if (i == 2) begin bHdr = 1; bSeq = 64'd8; bCnt = 16'd1; end
      if (i >= 3) begin bDv = 1; bData = 8'(8'h90 + i); bLast = (i == 5); end
      tick(); clr();
    end
    tick(); tick();
    chk("t4 busy", 64'(busyCnt), 64'd1);
    chk("t4 exp after", expSeq, 64'd8);
    chk_pkt("t4", 6, 8'h30, 0);

    // Error rollback, then B copy of the same sequence
    aHdr = 1; aSeq = 64'd8; aCnt = 16'd1;
    tick(); clr();
    chk("t5 exp", expSeq, 64'd9);
    for (int i = 0; i < 11; i++) begin
      aDv = 1; aData = 8'(8'h40 + i); aErr = (i == 10);
      tick(); clr();
    end
    tick(); tick();
    chk_pkt("t5", 11, 8'h40, 1);
    chk("t5 errCnt", 64'(errCnt), 64'd1);
    chk("t5 rollback", expSeq, 64'd8);
    bHdr = 1; bSeq = 64'd8; bCnt = 16'd1;
    tick(); clr();
    chk("t5 b exp", expSeq, 64'd9);
    chk("t5 b dup", 64'(dupCnt), 64'd1);
    for (int i = 0; i < 3; i++) begin
      bDv = 1; bData = 8'(8'h50 + i); bLast = (i == 2);
      tick(); clr();
    end
    tick(); tick();
    chk_pkt("t5b", 3, 8'h50, 0);

    // Heartbeat with gap, then end of session
    aHdr = 1; aSeq = 64'd20; aCnt = 16'd0;
    tick(); clr();
    chk("t6 gap", {63'd0, gap}, 64'd1);
    chk("t6 gapStart", gapStart, 64'd9);
    chk("t6 gapLen", 64'(gapLen), 64'd11);
    chk("t6 exp", expSeq, 64'd20);
    chk("t6 eos0", {63'd0, eos}, 64'd0);
    aHdr = 1; aSeq = 64'd20; aCnt = 16'hFFFF;
    tick(); clr();
    chk("t6 eos1", {63'd0, eos}, 64'd1);
    chk("t6 nogap", {63'd0, gap}, 64'd0);
    chk("t6 exp2", expSeq, 64'd20);
    tick();
    chk("t6 nodata", 64'(q.size()), 64'd0);

    // Header mid-packet aborts, rolls back, then classifies the new header
    aHdr = 1; aSeq = 64'd20; aCnt = 16'd1;
    tick(); clr();
    chk("t7 exp", expSeq, 64'd21);
    for (int i = 0; i < 2; i++) begin
      aDv = 1; aData = 8'(8'h60 + i);
      tick(); clr();
    end
    aHdr = 1; aSeq = 64'd21; aCnt = 16'd1;
    tick(); clr();
    chk("t7 exp new", expSeq, 64'd22);
    chk("t7 errCnt", 64'(errCnt), 64'd2);
    chk("t7 gap", {63'd0, gap}, 64'd1);
    chk("t7 gapStart", gapStart, 64'd20);
    chk("t7 gapLen", 64'(gapLen), 64'd1);
    aDv = 1; aData = 8'h70; aLast = 1;
    tick(); clr(); tick(); tick();
    chk("t7 count", 64'(q.size()), 64'd4);
    if (q.size() == 4) begin
      chk("t7 b0", 64'(q[0]), 64'h060);
      chk("t7 b1", 64'(q[1]), 64'h061);
      chk("t7 abort", 64'(q[2]), 64'h300);
      chk("t7 new", 64'(q[3]), 64'h170);
    end
    q.delete();

    // Gap length saturation
    aHdr = 1; aSeq = 64'h20016; aCnt = 16'd0;
    tick(); clr();
    chk("t8 gapLen sat", 64'(gapLen), 64'hFFFF);
    chk("t8 gapStart", gapStart, 64'd22);
    chk("t8 exp", expSeq, 64'h20016);
    chk("t8 cnts", {dupCnt, busyCnt}, {32'd1, 32'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
